life_gen_sequencer: RTL and testbench

Sequences one Game of Life generation step over a GRID_W x GRID_H grid held in an external two-bank (ping-pong) row memory. On a step request it streams the current-generation rows through a three-row window, evaluates every cell with the per-cell rule block, and writes the next generation into the opposite bank. On completion it flips the display bank. It sits between the frame memory and the display/scan-out logic and is the only writer of the grid during a step.

---
 rtl/life_gen_sequencer_pkg.sv | 14 +
 rtl/life_gen_sequencer_if.sv | 27 ++
 rtl/life_row_logic.sv | 17 +
 rtl/life_gen_sequencer.sv | 91 +++++++++
 tb/tb_life_gen_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_gen_sequencer_pkg.sv
// life_pkg: shared types, constants and the per-cell Game of Life rule.
package life_pkg;
  localparam int NEIGHBOURS_CNT = 8;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, FLUSH, DONE} state_e;
  function automatic int row_aw(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction
  function automatic logic cell_next(input logic alive, input logic [NEIGHBOURS_CNT-1:0] nb);
    int n;
    n = 0;
    for (int i = 0; i < NEIGHBOURS_CNT; i++) n += int'(nb[i]);
    return (n == 3) || (alive && n == 2);
  endfunction
endpackage

// File: rtl/life_gen_sequencer_if.sv
// life_gen_sequencer_if: step handshake plus ping-pong row memory ports.
interface life_gen_sequencer_if import life_pkg::*; #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int GEN_CNT_W = 16
) ();
  localparam int AW = row_aw(GRID_H);
  logic i_step, o_busy, o_done;
  logic o_rd_en, o_rd_bank;
  logic [AW-1:0] o_rd_addr;
  logic [GRID_W-1:0] i_rd_data;
  logic o_wr_en, o_wr_bank;
  logic [AW-1:0] o_wr_addr;
  logic [GRID_W-1:0] o_wr_data;
  logic o_disp_bank;
  logic [GEN_CNT_W-1:0] o_gen_count;
  modport master (
    input i_step, i_rd_data,
    output o_busy, o_done, o_rd_en, o_rd_bank, o_rd_addr, o_wr_en, o_wr_bank,
    o_wr_addr, o_wr_data, o_disp_bank, o_gen_count
  );
  modport slave (
    output i_step, i_rd_data,
    input o_busy, o_done, o_rd_en, o_rd_bank, o_rd_addr, o_wr_en, o_wr_bank,
    o_wr_addr, o_wr_data, o_disp_bank, o_gen_count
  );
endinterface

// File: rtl/life_row_logic.sv
// life_row_logic: next-generation row from a three-row window, dead borders.
module life_row_logic import life_pkg::*; #(
  parameter int GRID_W = 32
) (
  input  logic [GRID_W-1:0] above_i,
  input  logic [GRID_W-1:0] cur_i,
  input  logic [GRID_W-1:0] below_i,
  output logic [GRID_W-1:0] next_o
);
  logic [GRID_W+1:0] a_pad, c_pad, b_pad;
  assign a_pad = {1'b0, above_i, 1'b0};
  assign c_pad = {1'b0, cur_i, 1'b0};
  assign b_pad = {1'b0, below_i, 1'b0};
  for (genvar i = 0; i < GRID_W; i++) begin : g_cell
    assign next_o[i] = cell_next(c_pad[i+1], {a_pad[i+2:i], c_pad[i+2], c_pad[i], b_pad[i+2:i]});
  end
endmodule

// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: streams the displayed bank through a row window and
// writes the next generation into the other bank, then flips the display bank.
module life_gen_sequencer import life_pkg::*; #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int GEN_CNT_W = 16
) (
  input logic i_clk,
  input logic i_rst,
  life_gen_sequencer_if.master bus
);
  localparam int AW = row_aw(GRID_H);
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, wr_addr_q;
  logic rd_vld_q, vld2_q, wr_en_q, disp_q;
  logic [GEN_CNT_W-1:0] gen_q;
  logic [GRID_W-1:0] above_q, cur_q, below_q;
  logic accept, shift;
  assign accept = (state_q == IDLE) && bus.i_step;
  assign shift = rd_vld_q || (state_q == FLUSH);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (bus.i_step) begin
        state_d = READ;
        cnt_d = '0;
      end
      READ: begin
        cnt_d = (cnt_q == AW'(GRID_H - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == AW'(GRID_H - 1)) ? DRAIN : READ;
      end
      DRAIN: state_d = FLUSH;
      FLUSH: state_d = (wr_en_q && wr_addr_q == AW'(GRID_H - 1)) ? DONE : FLUSH;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Write strobe trails the read strobe by three cycles: memory latency plus two window shifts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_vld_q <= 1'b0;
      vld2_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      disp_q <= 1'b0;
      gen_q <= '0;
      above_q <= '0;
      cur_q <= '0;
      below_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_vld_q <= (state_q == READ);
      vld2_q <= rd_vld_q;
      wr_en_q <= vld2_q;
      wr_addr_q <= accept ? '0 : wr_addr_q + AW'(wr_en_q);
      if (accept) begin
        above_q <= '0;
        cur_q <= '0;
        below_q <= '0;
      end else if (shift) begin
        above_q <= cur_q;
        cur_q <= below_q;
        below_q <= rd_vld_q ? bus.i_rd_data : '0;
      end
      if (state_q == DONE) begin
        disp_q <= ~disp_q;
        gen_q <= gen_q + 1'b1;
      end
    end
  end
  assign bus.o_busy = (state_q != IDLE);
  assign bus.o_done = (state_q == DONE);
  assign bus.o_rd_en = (state_q == READ);
  assign bus.o_rd_bank = disp_q;
  assign bus.o_rd_addr = cnt_q;
  assign bus.o_wr_en = wr_en_q;
  assign bus.o_wr_bank = ~disp_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_disp_bank = disp_q;
  assign bus.o_gen_count = gen_q;
  life_row_logic #(.GRID_W(GRID_W)) u_row (
    .above_i(above_q),
    .cur_i(cur_q),
    .below_i(below_q),
    .next_o(bus.o_wr_data)
  );
endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb_life_gen_sequencer: directed checks on an 8x8 grid with a ping-pong memory model.
module tb_life_gen_sequencer;
  localparam int W = 8;
  localparam int H = 8;
  localparam int G = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mem [2][H];
  logic [W-1:0] img [H];
  logic ld = 1'b0;
  logic ld_bank = 1'b0;

  life_gen_sequencer_if #(.GRID_W(W), .GRID_H(H), .GEN_CNT_W(G)) bus ();
  life_gen_sequencer #(.GRID_W(W), .GRID_H(H), .GEN_CNT_W(G)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_bank][bus.o_rd_addr];
    if (bus.o_wr_en) mem[bus.o_wr_bank][bus.o_wr_addr] <= bus.o_wr_data;
    if (ld) for (int r = 0; r < H; r++) mem[ld_bank][r] <= img[r];
  end

  task automatic load_bank(input logic b);
    @(negedge clk);
    ld_bank = b;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic run_step();
    int done_cyc;
    done_cyc = -1;
    @(negedge clk);
    bus.i_step = 1'b1;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.i_step = 1'b0;
      if (bus.o_done) done_cyc = k;
    end
    checks++;
    if (done_cyc != H + 4) begin
      errors++;
      $display("FAIL step_done_cycle got %0d exp %0d", done_cyc, H + 4);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en, bus.o_rd_bank, bus.o_wr_bank, bus.o_disp_bank} !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_flags_in_rst got %b exp 0000010", {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en, bus.o_rd_bank, bus.o_wr_bank, bus.o_disp_bank});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en, bus.o_rd_bank, bus.o_wr_bank, bus.o_disp_bank} !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000010", {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en, bus.o_rd_bank, bus.o_wr_bank, bus.o_disp_bank});
    end
    checks++;
    if ({bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset_addr_data got %h exp 0", {bus.o_rd_addr, bus.o_wr_addr, bus.o_wr_data});
    end
    checks++;
    if (bus.o_gen_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_gen got %0d exp 0", bus.o_gen_count);
    end
  endtask

  task automatic test_blinker();
    logic [W-1:0] exp_row;
    for (int r = 0; r < H; r++) img[r] = (r == 3) ? 8'b0001_1100 : 8'h00;
    load_bank(1'b0);
    run_step();
    for (int r = 0; r < H; r++) begin
      exp_row = (r >= 2 && r <= 4) ? 8'b0000_1000 : 8'h00;
      checks++;
      if (mem[1][r] !== exp_row) begin
        errors++;
        $display("FAIL blinker1_row%0d got %b exp %b", r, mem[1][r], exp_row);
      end
    end
    checks++;
    if ({bus.o_gen_count, bus.o_disp_bank} !== {16'd1, 1'b1}) begin
      errors++;
      $display("FAIL blinker1_gen_disp got %0d/%b exp 1/1", bus.o_gen_count, bus.o_disp_bank);
    end
    for (int r = 0; r < H; r++) img[r] = 8'hFF;
    load_bank(1'b0);
    run_step();
    for (int r = 0; r < H; r++) begin
      exp_row = (r == 3) ? 8'b0001_1100 : 8'h00;
      checks++;
      if (mem[0][r] !== exp_row) begin
        errors++;
        $display("FAIL blinker2_row%0d got %b exp %b", r, mem[0][r], exp_row);
      end
    end
    checks++;
    if ({bus.o_gen_count, bus.o_disp_bank} !== {16'd2, 1'b0}) begin
      errors++;
      $display("FAIL blinker2_gen_disp got %0d/%b exp 2/0", bus.o_gen_count, bus.o_disp_bank);
    end
  endtask

  task automatic test_corner();
    logic [W-1:0] exp_row;
    for (int r = 0; r < H; r++) img[r] = (r < 2) ? 8'b0000_0011 : 8'h00;
    load_bank(1'b0);
    for (int r = 0; r < H; r++) img[r] = 8'hAA;
    load_bank(1'b1);
    run_step();
    for (int r = 0; r < H; r++) begin
      exp_row = (r < 2) ? 8'b0000_0011 : 8'h00;
      checks++;
      if (mem[1][r] !== exp_row) begin
        errors++;
        $display("FAIL block_row%0d got %b exp %b", r, mem[1][r], exp_row);
      end
    end
    for (int r = 0; r < H; r++) img[r] = (r == 0) ? 8'b1000_0000 : 8'h00;
    load_bank(1'b1);
    run_step();
    for (int r = 0; r < H; r++) begin
      checks++;
      if (mem[0][r] !== 8'h00) begin
        errors++;
        $display("FAIL single_row%0d got %b exp 00000000", r, mem[0][r]);
      end
    end
    checks++;
    if ({bus.o_gen_count, bus.o_disp_bank} !== {16'd4, 1'b0}) begin
      errors++;
      $display("FAIL corner_gen_disp got %0d/%b exp 4/0", bus.o_gen_count, bus.o_disp_bank);
    end
  endtask

  task automatic test_timing();
    logic [3:0] exp_f;
    for (int r = 0; r < H; r++) img[r] = (r == 3) ? 8'b0001_1100 : 8'h00;
    load_bank(1'b0);
    @(negedge clk);
    bus.i_step = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) bus.i_step = 1'b0;
      exp_f = {k >= 1 && k <= 12, k == 12, k >= 1 && k <= 8, k >= 4 && k <= 11};
      checks++;
      if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en} !== exp_f) begin
        errors++;
        $display("FAIL timing_flags_c%0d got %b exp %b", k, {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en}, exp_f);
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if ({bus.o_rd_bank, bus.o_rd_addr} !== {1'b0, 3'(k - 1)}) begin
          errors++;
          $display("FAIL timing_rd_c%0d got %b/%0d exp 0/%0d", k, bus.o_rd_bank, bus.o_rd_addr, k - 1);
        end
      end
      if (k >= 4 && k <= 11) begin
        checks++;
        if ({bus.o_wr_bank, bus.o_wr_addr} !== {1'b1, 3'(k - 4)}) begin
          errors++;
          $display("FAIL timing_wr_c%0d got %b/%0d exp 1/%0d", k, bus.o_wr_bank, bus.o_wr_addr, k - 4);
        end
      end
    end
    checks++;
    if ({bus.o_gen_count, bus.o_disp_bank} !== {16'd5, 1'b1}) begin
      errors++;
      $display("FAIL timing_gen_disp got %0d/%b exp 5/1", bus.o_gen_count, bus.o_disp_bank);
    end
  endtask

  task automatic test_ignore();
    for (int r = 0; r < H; r++) img[r] = 8'h00;
    load_bank(1'b1);
    @(negedge clk);
    bus.i_step = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus.i_step = (k == 3 || k == 12);
      if (k == 12 || k >= 13) begin
        checks++;
        if ({bus.o_busy, bus.o_done} !== ((k == 12) ? 2'b11 : 2'b00)) begin
          errors++;
          $display("FAIL ignore_busy_done_c%0d got %b exp %b", k, {bus.o_busy, bus.o_done}, (k == 12) ? 2'b11 : 2'b00);
        end
      end
    end
    checks++;
    if (bus.o_gen_count !== 16'd6) begin
      errors++;
      $display("FAIL ignore_gen got %0d exp 6", bus.o_gen_count);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    @(negedge clk);
    bus.i_step = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 30) bus.i_step = 1'b0;
      exp_done = (k == 12 || k == 25 || k == 38);
      checks++;
      if (bus.o_done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done_c%0d got %b exp %b", k, bus.o_done, exp_done);
      end
    end
    checks++;
    if ({bus.o_gen_count, bus.o_disp_bank, bus.o_busy} !== {16'd9, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_gen_disp_busy got %0d/%b/%b exp 9/1/0", bus.o_gen_count, bus.o_disp_bank, bus.o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int done_cyc;
    @(negedge clk);
    bus.i_step = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.i_step = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en, bus.o_disp_bank} !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_flags got %b exp 00000", {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en, bus.o_disp_bank});
    end
    checks++;
    if (bus.o_gen_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_gen got %0d exp 0", bus.o_gen_count);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_step = 1'b1;
    @(negedge clk);
    bus.i_step = 1'b0;
    checks++;
    if ({bus.o_rd_en, bus.o_rd_bank, bus.o_rd_addr} !== 5'b10000) begin
      errors++;
      $display("FAIL midrst_first_read got %b exp 10000", {bus.o_rd_en, bus.o_rd_bank, bus.o_rd_addr});
    end
    done_cyc = -1;
    for (int k = 2; k <= 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (bus.o_done) done_cyc = k;
    end
    checks++;
    if (done_cyc != H + 4) begin
      errors++;
      $display("FAIL midrst_done_cycle got %0d exp %0d", done_cyc, H + 4);
    end
    @(negedge clk);
    checks++;
    if ({bus.o_gen_count, bus.o_disp_bank} !== {16'd1, 1'b1}) begin
      errors++;
      $display("FAIL midrst_gen_disp got %0d/%b exp 1/1", bus.o_gen_count, bus.o_disp_bank);
    end
  endtask

  initial begin
    bus.i_step = 1'b0;
    test_reset();
    test_blinker();
    test_corner();
    test_timing();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
